// File: rtl/fpu_divsqrt_iter_pkg.sv
// Shared definitions for the iterative FDIV/FSQRT unit: FSM states, operand
// classes, FLAGS bit positions and the canonical quiet-NaN pattern.
package fpu_divsqrt_iter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ITER,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_e;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int QNAN_MAX_W = 128;

    // Positive qNaN: exponent all ones, only the fraction MSB set.
    function automatic logic [QNAN_MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
        logic [QNAN_MAX_W-1:0] one;
        one = QNAN_MAX_W'(1);
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational unpacker for one floating-point operand: sign, exponent,
// mantissa with hidden bit, and class. Subnormals are reported as zero.
module fpu_classify
    import fpu_divsqrt_iter_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] data,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp_field,
    output logic [MAN_W:0]       man,
    output fp_class_e            cls
);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;

    assign sign = data[EXP_W+MAN_W];
    assign e    = data[EXP_W+MAN_W-1:MAN_W];
    assign f    = data[MAN_W-1:0];

    always_comb begin
        exp_field = e;
        man       = {1'b1, f};
        cls       = CLS_NORMAL;
        if (e == '0) begin
            man = '0;
            cls = CLS_ZERO;
        end else if (&e) begin
            man = '0;
            if (f == '0)
                cls = CLS_INF;
            else if (f[MAN_W-1])
                cls = CLS_QNAN;
            else
                cls = CLS_SNAN;
        end
    end

endmodule

// File: rtl/fpu_divsqrt_iter.sv
// Iterative radix-2 restoring FDIV/FSQRT unit, one result bit per cycle.
// Define FPU_DIVSQRT_FLUSH_EN to add the FLUSH abort input.
module fpu_divsqrt_iter
    import fpu_divsqrt_iter_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic                 CLK,
    input  logic                 RESETN,
`ifdef FPU_DIVSQRT_FLUSH_EN
    input  logic                 FLUSH,
`endif
    input  logic                 START,
    input  logic                 OP,
    input  logic [EXP_W+MAN_W:0] DATA1,
    input  logic [EXP_W+MAN_W:0] DATA2,
    input  logic [TAG_W-1:0]     TAG_IN,
    output logic                 BUSY,
    output logic                 VALID_OUT,
    input  logic                 RESULT_READY,
    output logic [EXP_W+MAN_W:0] RESULT,
    output logic [TAG_W-1:0]     TAG_OUT,
    output logic [4:0]           FLAGS
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int QW    = MAN_W + 3;
    localparam int RW    = MAN_W + 6;
    localparam int XW    = 2 * MAN_W + 6;
    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = $clog2(QW);
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [QNAN_MAX_W-1:0] QNAN_FULL = qnan_bits(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN = QNAN_FULL[W-1:0];

    logic flush_req;
`ifdef FPU_DIVSQRT_FLUSH_EN
    assign flush_req = FLUSH;
`else
    assign flush_req = 1'b0;
`endif

    state_e                 state;
    logic                   op_q, sign_q, special_q;
    logic [W-1:0]           a_q, b_q, spec_res_q;
    logic [4:0]             spec_flags_q;
    logic signed [EW-1:0]   exp_q;
    logic [RW-1:0]          rem_q;
    logic [QW-1:0]          quo_q;
    logic [XW-1:0]          rad_q;
    logic [MAN_W:0]         dsr_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   sa, sb;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W:0]         ma, mb;
    fp_class_e              ca, cb;

    fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .data(a_q), .sign(sa), .exp_field(ea), .man(ma), .cls(ca)
    );
    fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .data(b_q), .sign(sb), .exp_field(eb), .man(mb), .cls(cb)
    );

    logic signed [EW-1:0] ea_s, eb_s, e_unb;
    logic [MAN_W+1:0]     sq_man;
    assign ea_s   = signed'(EW'(ea));
    assign eb_s   = signed'(EW'(eb));
    assign e_unb  = ea_s - BIAS;
    // Odd unbiased exponent: fold one power of two into the radicand.
    assign sq_man = e_unb[0] ? {ma, 1'b0} : {1'b0, ma};

    logic         spec_hit, res_sign;
    logic [W-1:0] spec_res, inf_r, zero_r;
    logic [4:0]   spec_flags;

    always_comb begin
        spec_hit   = 1'b1;
        spec_flags = '0;
        spec_res   = QNAN;
        res_sign   = op_q ? sa : (sa ^ sb);
        inf_r      = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        zero_r     = {res_sign, {(EXP_W + MAN_W){1'b0}}};
        if (op_q) begin
            if (ca == CLS_SNAN) begin
                spec_flags[FLAG_NV] = 1'b1;
            end else if (ca == CLS_QNAN) begin
                spec_res = QNAN;
            end else if (ca == CLS_ZERO) begin
                spec_res = zero_r;
            end else if (sa) begin
                spec_flags[FLAG_NV] = 1'b1;
            end else if (ca == CLS_INF) begin
                spec_res = inf_r;
            end else begin
                spec_hit = 1'b0;
            end
        end else begin
            if (ca == CLS_SNAN || cb == CLS_SNAN) begin
                spec_flags[FLAG_NV] = 1'b1;
            end else if (ca == CLS_QNAN || cb == CLS_QNAN) begin
                spec_res = QNAN;
            end else if ((ca == CLS_ZERO && cb == CLS_ZERO) || (ca == CLS_INF && cb == CLS_INF)) begin
                spec_flags[FLAG_NV] = 1'b1;
            end else if (ca == CLS_INF) begin
                spec_res = inf_r;
            end else if (cb == CLS_ZERO) begin
                spec_res            = inf_r;
                spec_flags[FLAG_DZ] = 1'b1;
            end else if (ca == CLS_ZERO || cb == CLS_INF) begin
                spec_res = zero_r;
            end else begin
                spec_hit = 1'b0;
            end
        end
    end

    // One restoring step: divide compares against the divisor, square root
    // brings down two radicand bits and compares against (root << 2) | 1.
    logic [RW-1:0] rem_sh, trial, rem_nx;
    logic          bit_nx;

    always_comb begin
        if (op_q) begin
            rem_sh = {rem_q[RW-3:0], rad_q[XW-1 -: 2]};
            trial  = RW'({quo_q, 2'b01});
        end else begin
            rem_sh = rem_q;
            trial  = RW'(dsr_q);
        end
        bit_nx = (rem_sh >= trial);
        rem_nx = bit_nx ? (rem_sh - trial) : rem_sh;
        if (!op_q)
            rem_nx = rem_nx << 1;
    end

    logic [MAN_W:0]       mant;
    logic [MAN_W+1:0]     mant_r;
    logic [MAN_W-1:0]     frac_r;
    logic                 guard, sticky, rup;
    logic signed [EW-1:0] exp_r;
    logic [W-1:0]         rnd_res;
    logic [4:0]           rnd_flags;

    always_comb begin
        mant      = quo_q[QW-1:2];
        guard     = quo_q[1];
        sticky    = quo_q[0] | (rem_q != '0);
        rup       = guard & (sticky | mant[0]);
        mant_r    = {1'b0, mant} + (MAN_W + 2)'(rup);
        frac_r    = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        exp_r     = exp_q + (mant_r[MAN_W+1] ? EW'(1) : EW'(0));
        rnd_flags = '0;
        rnd_flags[FLAG_NX] = guard | sticky;
        rnd_res   = {sign_q, exp_r[EXP_W-1:0], frac_r};
        if (exp_r >= EXP_MAX) begin
            rnd_res            = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags[FLAG_OF] = 1'b1;
            rnd_flags[FLAG_NX] = 1'b1;
        end else if (exp_r <= EW'(0)) begin
            rnd_res            = {sign_q, {(EXP_W + MAN_W){1'b0}}};
            rnd_flags[FLAG_UF] = 1'b1;
            rnd_flags[FLAG_NX] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state        <= S_IDLE;
            op_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            rad_q        <= '0;
            dsr_q        <= '0;
            cnt_q        <= '0;
            special_q    <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            BUSY         <= 1'b0;
            VALID_OUT    <= 1'b0;
            RESULT       <= '0;
            TAG_OUT      <= '0;
            FLAGS        <= '0;
        end else if (flush_req) begin
            state     <= S_IDLE;
            BUSY      <= 1'b0;
            VALID_OUT <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        op_q    <= OP;
                        a_q     <= DATA1;
                        b_q     <= DATA2;
                        TAG_OUT <= TAG_IN;
                        BUSY    <= 1'b1;
                        state   <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    quo_q <= '0;
                    // Specials skip the iteration but still take the ROUND slot.
                    if (spec_hit) begin
                        special_q    <= 1'b1;
                        spec_res_q   <= spec_res;
                        spec_flags_q <= spec_flags;
                        state        <= S_ROUND;
                    end else begin
                        special_q <= 1'b0;
                        cnt_q     <= CNT_W'(QW - 1);
                        state     <= S_ITER;
                        if (op_q) begin
                            sign_q <= 1'b0;
                            exp_q  <= (e_unb >>> 1) + BIAS;
                            rem_q  <= '0;
                            rad_q  <= {sq_man, {(MAN_W + 4){1'b0}}};
                        end else begin
                            sign_q <= sa ^ sb;
                            exp_q  <= ea_s - eb_s + BIAS;
                            rem_q  <= RW'(ma);
                            dsr_q  <= mb;
                        end
                    end
                end
                S_ITER: begin
                    rem_q <= rem_nx;
                    quo_q <= {quo_q[QW-2:0], bit_nx};
                    rad_q <= rad_q << 2;
                    if (cnt_q == '0)
                        state <= S_NORM;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                S_NORM: begin
                    if (!op_q && !quo_q[QW-1]) begin
                        quo_q <= quo_q << 1;
                        exp_q <= exp_q - EW'(1);
                    end
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    RESULT    <= special_q ? spec_res_q : rnd_res;
                    FLAGS     <= special_q ? spec_flags_q : rnd_flags;
                    VALID_OUT <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (RESULT_READY) begin
                        VALID_OUT <= 1'b0;
                        BUSY      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Self-checking bench for fpu_divsqrt_iter (single precision), with an
// expected-result queue filled at issue and drained at the handshake.
module tb_fpu_divsqrt_iter;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic         START = 1'b0;
    logic         OP = 1'b0;
    logic         RESULT_READY = 1'b0;
    logic [W-1:0] DATA1 = '0;
    logic [W-1:0] DATA2 = '0;
    logic [4:0]   TAG_IN = '0;
    logic         BUSY, VALID_OUT;
    logic [W-1:0] RESULT;
    logic [4:0]   TAG_OUT, FLAGS;
`ifdef FPU_DIVSQRT_FLUSH_EN
    logic         FLUSH = 1'b0;
`endif

    logic [W+9:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    localparam logic [4:0] F_NV = 5'h10;
    localparam logic [4:0] F_DZ = 5'h08;
    localparam logic [4:0] F_OF = 5'h04;
    localparam logic [4:0] F_UF = 5'h02;
    localparam logic [4:0] F_NX = 5'h01;

    fpu_divsqrt_iter #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
        .CLK(CLK),
        .RESETN(RESETN),
`ifdef FPU_DIVSQRT_FLUSH_EN
        .FLUSH(FLUSH),
`endif
        .START(START),
        .OP(OP),
        .DATA1(DATA1),
        .DATA2(DATA2),
        .TAG_IN(TAG_IN),
        .BUSY(BUSY),
        .VALID_OUT(VALID_OUT),
        .RESULT_READY(RESULT_READY),
        .RESULT(RESULT),
        .TAG_OUT(TAG_OUT),
        .FLAGS(FLAGS)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; the accept edge falls inside this task.
    task automatic issue(input logic op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                         input logic [4:0] tag, input logic [W-1:0] er, input logic [4:0] ef);
        START  = 1'b1;
        OP     = op;
        DATA1  = d1;
        DATA2  = d2;
        TAG_IN = tag;
        exp_q.push_back({er, ef, tag});
        @(negedge CLK);
        START  = 1'b0;
        OP     = 1'($urandom_range(0, 1));
        DATA1  = $urandom;
        DATA2  = $urandom;
        TAG_IN = 5'($urandom_range(0, 31));
    endtask

    task automatic collect(input int exp_lat, input int hold);
        int           lat;
        logic [W+9:0] e;
        lat = 0;
        check("busy_after_accept", 64'(BUSY), 64'(1));
        while (!VALID_OUT && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        e = '0;
        if (exp_q.size() > 0)
            e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            START  = ~i[0];
            OP     = 1'($urandom_range(0, 1));
            DATA1  = $urandom;
            DATA2  = $urandom;
            TAG_IN = 5'($urandom_range(0, 31));
            @(negedge CLK);
        end
        START = 1'b0;
        if (hold > 0)
            check("valid_held", 64'(VALID_OUT), 64'(1));
        check("result", 64'(RESULT), 64'(e[W+9:10]));
        check("flags", 64'(FLAGS), 64'(e[9:5]));
        check("tag", 64'(TAG_OUT), 64'(e[4:0]));
        RESULT_READY = 1'b1;
        @(negedge CLK);
        RESULT_READY = 1'b0;
        check("valid_drop", 64'(VALID_OUT), 64'(0));
        check("busy_drop", 64'(BUSY), 64'(0));
    endtask

    task automatic run_op(input logic op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                          input logic [4:0] tag, input logic [W-1:0] er, input logic [4:0] ef,
                          input int lat);
        issue(op, d1, d2, tag, er, ef);
        collect(lat, 0);
    endtask

    initial begin
        logic       sa, sb;
        logic [7:0] ea, eb;
        logic [22:0] fa;
        int         nv;

        repeat (3) @(negedge CLK);
        RESETN = 1'b1;
        @(negedge CLK);
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_valid", 64'(VALID_OUT), 64'(0));
        check("rst_result", 64'(RESULT), 64'(0));
        check("rst_tag", 64'(TAG_OUT), 64'(0));
        check("rst_flags", 64'(FLAGS), 64'(0));

        run_op(1'b0, 32'h40C00000, 32'h40400000, 5'd1, 32'h40000000, 5'h00, 29);
        run_op(1'b0, 32'h3F800000, 32'h40400000, 5'd2, 32'h3EAAAAAB, F_NX, 29);
        run_op(1'b1, 32'h40000000, 32'h12345678, 5'd3, 32'h3FB504F3, F_NX, 29);
        run_op(1'b1, 32'h40800000, 32'h0, 5'd4, 32'h40000000, 5'h00, 29);
        run_op(1'b0, 32'h3F800000, 32'h00000000, 5'd5, 32'h7F800000, F_DZ, 2);
        run_op(1'b1, 32'hBF800000, 32'h0, 5'd6, 32'h7FC00000, F_NV, 2);
        run_op(1'b0, 32'hC0F00000, 32'h40200000, 5'd8, 32'hC0400000, 5'h00, 29);
        run_op(1'b1, 32'h41100000, 32'h0, 5'd9, 32'h40400000, 5'h00, 29);
        run_op(1'b1, 32'h3E800000, 32'h0, 5'd10, 32'h3F000000, 5'h00, 29);
        run_op(1'b0, 32'h7F800001, 32'h3F800000, 5'd11, 32'h7FC00000, F_NV, 2);
        run_op(1'b0, 32'h7FC00000, 32'h3F800000, 5'd12, 32'h7FC00000, 5'h00, 2);
        run_op(1'b0, 32'h00000000, 32'h80000000, 5'd13, 32'h7FC00000, F_NV, 2);
        run_op(1'b0, 32'hFF800000, 32'h7F800000, 5'd14, 32'h7FC00000, F_NV, 2);
        run_op(1'b0, 32'h80000000, 32'h40A00000, 5'd15, 32'h80000000, 5'h00, 2);
        run_op(1'b0, 32'hFF800000, 32'h40000000, 5'd16, 32'hFF800000, 5'h00, 2);
        run_op(1'b0, 32'h40000000, 32'hFF800000, 5'd17, 32'h80000000, 5'h00, 2);
        run_op(1'b1, 32'h80000000, 32'h0, 5'd18, 32'h80000000, 5'h00, 2);
        run_op(1'b1, 32'h7F800000, 32'h0, 5'd19, 32'h7F800000, 5'h00, 2);
        run_op(1'b0, 32'h00400000, 32'h3F800000, 5'd20, 32'h00000000, 5'h00, 2);
        run_op(1'b0, 32'h7F000000, 32'h3E800000, 5'd21, 32'h7F800000, F_OF | F_NX, 29);
        run_op(1'b0, 32'h00800000, 32'h40000000, 5'd22, 32'h00000000, F_UF | F_NX, 29);

        // Division by a power of two only shifts the exponent.
        for (int i = 0; i < 6; i++) begin
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            ea = 8'($urandom_range(100, 150));
            eb = 8'($urandom_range(110, 140));
            fa = 23'($urandom);
            run_op(1'b0, {sa, ea, fa}, {sb, eb, 23'h0}, 5'(i + 24),
                   {sa ^ sb, 8'(ea - eb + 8'd127), fa}, 5'h00, 29);
        end

        // Result held while the consumer stalls; START is ignored meanwhile.
        issue(1'b0, 32'h40C00000, 32'h40400000, 5'd3, 32'h40000000, 5'h00);
        collect(29, 10);
        run_op(1'b0, 32'h3F800000, 32'h40400000, 5'd12, 32'h3EAAAAAB, F_NX, 29);

        // Reset in the middle of the iteration abandons the operation.
        issue(1'b0, 32'h40C00000, 32'h40400000, 5'd4, 32'h40000000, 5'h00);
        repeat (11) @(negedge CLK);
        RESETN = 1'b0;
        #1;
        check("midrst_busy", 64'(BUSY), 64'(0));
        check("midrst_valid", 64'(VALID_OUT), 64'(0));
        exp_q.delete();
        @(negedge CLK);
        RESETN = 1'b1;
        nv = 0;
        repeat (35) begin
            @(negedge CLK);
            if (VALID_OUT)
                nv++;
        end
        check("no_result_after_reset", 64'(nv), 64'(0));
        run_op(1'b0, 32'h3F800000, 32'h40400000, 5'd7, 32'h3EAAAAAB, F_NX, 29);

`ifdef FPU_DIVSQRT_FLUSH_EN
        issue(1'b1, 32'h40000000, 32'h0, 5'd9, 32'h3FB504F3, F_NX);
        repeat (10) @(negedge CLK);
        FLUSH = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        START = 1'b0;
        check("flush_busy", 64'(BUSY), 64'(0));
        check("flush_valid", 64'(VALID_OUT), 64'(0));
        exp_q.delete();
        nv = 0;
        repeat (35) begin
            @(negedge CLK);
            if (VALID_OUT)
                nv++;
        end
        check("no_result_after_flush", 64'(nv), 64'(0));
        run_op(1'b1, 32'h40800000, 32'h0, 5'd11, 32'h40000000, 5'h00, 29);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
